// File: rtl/ctrl_decode_pipe.sv
// ID-stage controller: decodes RV32I (+RV32M) into a registered control bundle
// with valid/ready handshake, flush, and a counter that holds DIV/REM issue.
module ctrl_decode_pipe #(
    parameter bit EN_M       = 1'b1,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        rf_re0,
    output logic        rf_re1,
    output logic        rf_we,
    output logic [1:0]  rf_wd_sel,
    output logic [2:0]  imm_type,
    output logic        alu_src1_sel,
    output logic        alu_src2_sel,
    output logic [4:0]  alu_func,
    output logic [2:0]  br_type,
    output logic        jal,
    output logic        jalr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [2:0]  mem_width,
    output logic        ebreak,
    output logic        illegal,
    output logic        md_busy
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic {IDLE, MD_WAIT} state_t;

    typedef struct packed {
        logic       re0;
        logic       re1;
        logic       we;
        logic [1:0] wdSel;
        logic [2:0] immType;
        logic       src1;
        logic       src2;
        logic [4:0] aluFunc;
        logic [2:0] brType;
        logic       jal;
        logic       jalr;
        logic       memRe;
        logic       memWe;
        logic [2:0] memWidth;
        logic       ebreak;
        logic       illegal;
    } bundle_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    logic       decIsDiv;
    bundle_t    dec;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    bundle_t          bundle_q, bundle_d;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    function automatic logic [4:0] baseAlu(input logic [2:0] fn3, input logic arith);
        case (fn3)
            3'b000:  return 5'd0;
            3'b001:  return 5'd9;
            3'b010:  return 5'd2;
            3'b011:  return 5'd3;
            3'b100:  return 5'd4;
            3'b101:  return arith ? 5'd11 : 5'd8;
            3'b110:  return 5'd6;
            default: return 5'd5;
        endcase
    endfunction

    // Format-level decode first; register-zero qualification and illegal
    // squashing are applied afterwards so each opcode arm stays simple.
    always_comb begin
        dec      = '0;
        bad      = 1'b0;
        decIsDiv = 1'b0;
        dec.src2 = (opc != OP_ARITH);
        case (opc)
            OP_LUI: begin
                dec.we = 1'b1; dec.wdSel = 2'd3; dec.immType = 3'd4; dec.aluFunc = 5'd10;
            end
            OP_AUIPC: begin
                dec.we = 1'b1; dec.immType = 3'd4; dec.src1 = 1'b1;
            end
            OP_JAL: begin
                dec.we = 1'b1; dec.wdSel = 2'd1; dec.immType = 3'd5; dec.src1 = 1'b1; dec.jal = 1'b1;
            end
            OP_JALR: begin
                dec.re0 = 1'b1; dec.we = 1'b1; dec.wdSel = 2'd1; dec.immType = 3'd1; dec.jalr = 1'b1;
            end
            OP_BRANCH: begin
                dec.re0 = 1'b1; dec.re1 = 1'b1; dec.immType = 3'd3; dec.src1 = 1'b1;
                case (f3)
                    3'b000:  dec.brType = 3'd6;
                    3'b001:  dec.brType = 3'd1;
                    3'b100:  dec.brType = 3'd2;
                    3'b101:  dec.brType = 3'd3;
                    3'b110:  dec.brType = 3'd4;
                    3'b111:  dec.brType = 3'd5;
                    default: bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.re0 = 1'b1; dec.we = 1'b1; dec.wdSel = 2'd2; dec.immType = 3'd1;
                dec.memRe = 1'b1; dec.memWidth = f3;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                dec.re0 = 1'b1; dec.re1 = 1'b1; dec.immType = 3'd2;
                dec.memWe = 1'b1; dec.memWidth = f3;
                bad = (f3 > 3'b010);
            end
            OP_ARITHI: begin
                dec.re0 = 1'b1; dec.we = 1'b1; dec.immType = 3'd1;
                dec.aluFunc = baseAlu(f3, inst[30]);
            end
            OP_ARITH: begin
                dec.re0 = 1'b1; dec.re1 = 1'b1; dec.we = 1'b1;
                case (f7)
                    7'b0000000: dec.aluFunc = baseAlu(f3, 1'b0);
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec.aluFunc = 5'd1;
                        else if (f3 == 3'b101) dec.aluFunc = 5'd11;
                        else                   bad = 1'b1;
                    end
                    7'b0000001: begin
                        if (EN_M) begin
                            dec.aluFunc = {2'b10, f3};
                            decIsDiv    = f3[2];
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_SYSTEM: dec.ebreak = 1'b1;
            OP_FENCE:  ;
            default:   bad = 1'b1;
        endcase
        dec.re0     = dec.re0 & (inst[19:15] != 5'd0);
        dec.re1     = dec.re1 & (inst[24:20] != 5'd0);
        dec.we      = dec.we & (inst[11:7] != 5'd0) & ~bad;
        dec.illegal = bad;
        if (bad) begin
            dec.memRe    = 1'b0;
            dec.memWe    = 1'b0;
            dec.memWidth = 3'd0;
            dec.jal      = 1'b0;
            dec.jalr     = 1'b0;
            dec.brType   = 3'd0;
        end
    end

    assign in_ready = (state_q == IDLE) & (~valid_q | out_ready);

    // Flush outranks both acceptance and the end of a divide countdown.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            valid_d  = 1'b0;
            bundle_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        bundle_d = dec;
                        if (decIsDiv) begin
                            state_d = MD_WAIT;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            valid_d = 1'b0;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else if (out_ready) begin
                        valid_d = 1'b0;
                    end
                end
                MD_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid    = valid_q;
    assign md_busy      = (state_q == MD_WAIT);
    assign rf_re0       = bundle_q.re0;
    assign rf_re1       = bundle_q.re1;
    assign rf_we        = bundle_q.we;
    assign rf_wd_sel    = bundle_q.wdSel;
    assign imm_type     = bundle_q.immType;
    assign alu_src1_sel = bundle_q.src1;
    assign alu_src2_sel = bundle_q.src2;
    assign alu_func     = bundle_q.aluFunc;
    assign br_type      = bundle_q.brType;
    assign jal          = bundle_q.jal;
    assign jalr         = bundle_q.jalr;
    assign mem_re       = bundle_q.memRe;
    assign mem_we       = bundle_q.memWe;
    assign mem_width    = bundle_q.memWidth;
    assign ebreak       = bundle_q.ebreak;
    assign illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (EN_M=1 and EN_M=0, DIV_CYCLES=4)
// share inputs and are compared each cycle against an instruction-level model.
module tb_ctrl_decode_pipe;

    localparam int DIVC = 4;

    typedef struct packed {
        logic       re0;
        logic       re1;
        logic       we;
        logic [1:0] wdSel;
        logic [2:0] immType;
        logic       src1;
        logic       src2;
        logic [4:0] aluFunc;
        logic [2:0] brType;
        logic       jal;
        logic       jalr;
        logic       memRe;
        logic       memWe;
        logic [2:0] memWidth;
        logic       ebreak;
        logic       illegal;
    } bundle_t;

    logic        clk;
    logic        rstn;
    logic        inValid  = 1'b0;
    logic [31:0] inst     = 32'h0;
    logic        flush    = 1'b0;
    logic        outReady = 1'b0;

    logic       oValid[2], iReady[2], mdBusy[2], re0[2], re1[2], we[2], src1[2], src2[2];
    logic       jal[2], jalr[2], memRe[2], memWe[2], ebrk[2], ill[2];
    logic [1:0] wdSel[2];
    logic [2:0] immT[2], brT[2], memW[2];
    logic [4:0] aluF[2];

    int checks = 0;
    int errors = 0;

    bit      mValid[2];
    int      mRem[2];
    bundle_t mBundle[2];

    ctrl_decode_pipe #(.EN_M(1'b1), .DIV_CYCLES(DIVC), .CNT_W(8)) u_dutM (
        .clk(clk), .rstn(rstn), .in_valid(inValid), .in_ready(iReady[0]), .inst(inst),
        .flush(flush), .out_valid(oValid[0]), .out_ready(outReady),
        .rf_re0(re0[0]), .rf_re1(re1[0]), .rf_we(we[0]), .rf_wd_sel(wdSel[0]),
        .imm_type(immT[0]), .alu_src1_sel(src1[0]), .alu_src2_sel(src2[0]),
        .alu_func(aluF[0]), .br_type(brT[0]), .jal(jal[0]), .jalr(jalr[0]),
        .mem_re(memRe[0]), .mem_we(memWe[0]), .mem_width(memW[0]),
        .ebreak(ebrk[0]), .illegal(ill[0]), .md_busy(mdBusy[0])
    );

    ctrl_decode_pipe #(.EN_M(1'b0), .DIV_CYCLES(DIVC), .CNT_W(8)) u_dutN (
        .clk(clk), .rstn(rstn), .in_valid(inValid), .in_ready(iReady[1]), .inst(inst),
        .flush(flush), .out_valid(oValid[1]), .out_ready(outReady),
        .rf_re0(re0[1]), .rf_re1(re1[1]), .rf_we(we[1]), .rf_wd_sel(wdSel[1]),
        .imm_type(immT[1]), .alu_src1_sel(src1[1]), .alu_src2_sel(src2[1]),
        .alu_func(aluF[1]), .br_type(brT[1]), .jal(jal[1]), .jalr(jalr[1]),
        .mem_re(memRe[1]), .mem_we(memWe[1]), .mem_width(memW[1]),
        .ebreak(ebrk[1]), .illegal(ill[1]), .md_busy(mdBusy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bundle_t dutBundle(input int k);
        bundle_t b;
        b = '{re0[k], re1[k], we[k], wdSel[k], immT[k], src1[k], src2[k], aluF[k],
              brT[k], jal[k], jalr[k], memRe[k], memWe[k], memW[k], ebrk[k], ill[k]};
        return b;
    endfunction

    // Reference decode, written per instruction class from the ISA rules.
    function automatic bundle_t modelDecode(input logic [31:0] w, input bit enM);
        bundle_t b;
        int   aluTbl[8] = '{0, 9, 2, 3, 4, 8, 6, 5};
        int   brTbl[8]  = '{6, 1, -1, -1, 2, 3, 4, 5};
        int   f3 = int'(w[14:12]);
        bit   r1 = (w[19:15] != 0);
        bit   r2 = (w[24:20] != 0);
        bit   wr = (w[11:7] != 0);
        b = '0;
        b.src2 = 1'b1;
        case (w[6:0])
            7'b0110111: begin b.we = wr; b.wdSel = 3; b.immType = 4; b.aluFunc = 10; end
            7'b0010111: begin b.we = wr; b.immType = 4; b.src1 = 1; end
            7'b1101111: begin b.we = wr; b.wdSel = 1; b.immType = 5; b.src1 = 1; b.jal = 1; end
            7'b1100111: begin b.re0 = r1; b.we = wr; b.wdSel = 1; b.immType = 1; b.jalr = 1; end
            7'b1100011: begin
                b.re0 = r1; b.re1 = r2; b.immType = 3; b.src1 = 1;
                if (brTbl[f3] < 0) b.illegal = 1; else b.brType = 3'(brTbl[f3]);
            end
            7'b0000011: begin
                b.re0 = r1; b.wdSel = 2; b.immType = 1;
                if (f3 == 3 || f3 >= 6) b.illegal = 1;
                else begin b.we = wr; b.memRe = 1; b.memWidth = 3'(f3); end
            end
            7'b0100011: begin
                b.re0 = r1; b.re1 = r2; b.immType = 2;
                if (f3 > 2) b.illegal = 1;
                else begin b.memWe = 1; b.memWidth = 3'(f3); end
            end
            7'b0010011: begin
                b.re0 = r1; b.we = wr; b.immType = 1;
                b.aluFunc = (f3 == 5 && w[30]) ? 5'd11 : 5'(aluTbl[f3]);
            end
            7'b0110011: begin
                b.re0 = r1; b.re1 = r2; b.src2 = 0;
                if (w[31:25] == 7'h00)                b.aluFunc = 5'(aluTbl[f3]);
                else if (w[31:25] == 7'h20 && f3 == 0) b.aluFunc = 1;
                else if (w[31:25] == 7'h20 && f3 == 5) b.aluFunc = 11;
                else if (w[31:25] == 7'h01 && enM)     b.aluFunc = 5'(16 + f3);
                else                                   b.illegal = 1;
                b.we = wr && !b.illegal;
            end
            7'b1110011: b.ebreak = 1;
            7'b0001111: ;
            default:    b.illegal = 1;
        endcase
        return b;
    endfunction

    function automatic bit isDiv(input logic [31:0] w, input bit enM);
        return enM && w[6:0] == 7'b0110011 && w[31:25] == 7'h01 && w[14];
    endfunction

    function automatic logic [31:0] randInst();
        logic [31:0] w;
        logic [6:0]  o;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[11:7]  = 5'd0;
        if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
        if ($urandom_range(0, 3) == 0) w[24:20] = 5'd0;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'b0110111;
            1: w[6:0] = 7'b0010111;
            2: w[6:0] = 7'b1101111;
            3: w[6:0] = 7'b1100111;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b0000011;
            6: w[6:0] = 7'b0100011;
            7: w[6:0] = 7'b0010011;
            8, 9: begin
                w[6:0] = 7'b0110011;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            10: w = ($urandom_range(0, 1) == 1) ? 32'h00100073 : 32'h00000073;
            default: begin
                do o = 7'($urandom);
                while (o inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011,
                                 7'b0001111});
                w[6:0] = o;
            end
        endcase
        return w;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBundle(input string name, input bundle_t act, input bundle_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                mValid[k] = 0; mRem[k] = 0; mBundle[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (flush) begin
                    mValid[k] = 0; mRem[k] = 0; mBundle[k] = '0;
                end else if (mRem[k] > 0) begin
                    mRem[k]--;
                    if (mRem[k] == 0) mValid[k] = 1;
                end else if (inValid && (!mValid[k] || outReady)) begin
                    mBundle[k] = modelDecode(inst, k == 0);
                    if (isDiv(inst, k == 0)) begin
                        mRem[k] = DIVC; mValid[k] = 0;
                    end else begin
                        mValid[k] = 1;
                    end
                end else if (outReady) begin
                    mValid[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            checkVal($sformatf("out_valid[%0d]", k), int'(oValid[k]), int'(mValid[k]));
            checkVal($sformatf("md_busy[%0d]", k), int'(mdBusy[k]), int'(mRem[k] > 0));
            checkVal($sformatf("in_ready[%0d]", k), int'(iReady[k]),
                     int'(mRem[k] == 0 && (!mValid[k] || outReady)));
            if (mValid[k])
                checkBundle($sformatf("bundle[%0d]", k), dutBundle(k), mBundle[k]);
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] i, input logic f, input logic r);
        inValid  = v;
        inst     = i;
        flush    = f;
        outReady = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checkVal(name, act, exp);
    endtask

    localparam logic [31:0] ADD = 32'h002081B3;
    localparam logic [31:0] LW  = 32'h00412083;
    localparam logic [31:0] DIV = 32'h027342B3;
    localparam logic [31:0] XOR = 32'h0020C1B3;

    initial begin
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("rst out_valid", int'(oValid[k]), 0);
            checkOutput("rst in_ready", int'(iReady[k]), 1);
            checkBundle("rst bundle", dutBundle(k), '0);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1, ADD, 0, 1);
        checkOutput("add out_valid", int'(oValid[0]), 1);
        checkOutput("add alu_func", int'(aluF[0]), 0);
        checkOutput("add rf_we", int'(we[0]), 1);
        checkOutput("add rf_re0", int'(re0[0]), 1);
        checkOutput("add rf_re1", int'(re1[0]), 1);
        checkOutput("add src2", int'(src2[0]), 0);
        checkOutput("add imm_type", int'(immT[0]), 0);

        applyStimulus(1, LW, 0, 1);
        checkOutput("lw mem_re", int'(memRe[0]), 1);
        checkOutput("lw mem_width", int'(memW[0]), 2);
        checkOutput("lw wd_sel", int'(wdSel[0]), 2);
        checkOutput("lw imm_type", int'(immT[0]), 1);
        checkOutput("lw src2", int'(src2[0]), 1);
        checkOutput("lw rf_re1", int'(re1[0]), 0);

        applyStimulus(1, DIV, 0, 1);
        checkOutput("div nom illegal", int'(ill[1]), 1);
        checkOutput("div nom rf_we", int'(we[1]), 0);
        checkOutput("div nom out_valid", int'(oValid[1]), 1);
        for (int c = 1; c <= DIVC; c++) begin
            checkOutput($sformatf("div busy c%0d", c), int'(mdBusy[0]), 1);
            checkOutput($sformatf("div in_ready c%0d", c), int'(iReady[0]), 0);
            checkOutput($sformatf("div out_valid c%0d", c), int'(oValid[0]), 0);
            applyStimulus(1, ADD, 0, 1);
        end
        checkOutput("div done out_valid", int'(oValid[0]), 1);
        checkOutput("div done alu_func", int'(aluF[0]), 20);
        checkOutput("div done md_busy", int'(mdBusy[0]), 0);
        checkOutput("div done in_ready", int'(iReady[0]), 1);
        applyStimulus(1, ADD, 0, 1);
        checkOutput("post-div add alu", int'(aluF[0]), 0);
        checkOutput("post-div add valid", int'(oValid[0]), 1);

        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, XOR, 0, 0);
            checkOutput("stall out_valid", int'(oValid[0]), 1);
            checkOutput("stall alu_func", int'(aluF[0]), 0);
            checkOutput("stall in_ready", int'(iReady[0]), 0);
        end
        applyStimulus(1, XOR, 0, 1);
        checkOutput("unstall xor alu", int'(aluF[0]), 4);

        applyStimulus(1, DIV, 0, 1);
        applyStimulus(0, 32'h0, 0, 1);
        applyStimulus(1, ADD, 1, 1);
        checkOutput("flush md_busy", int'(mdBusy[0]), 0);
        checkOutput("flush out_valid", int'(oValid[0]), 0);
        checkOutput("flush in_ready", int'(iReady[0]), 1);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 32'h0, 0, 1);
            checkOutput("post-flush out_valid", int'(oValid[0]), 0);
        end

        applyStimulus(1, DIV, 0, 1);
        applyStimulus(0, 32'h0, 0, 1);
        #3 rstn = 1'b0;
        #1;
        checkOutput("rst-wait md_busy", int'(mdBusy[0]), 0);
        checkOutput("rst-wait out_valid", int'(oValid[0]), 0);
        checkBundle("rst-wait bundle", dutBundle(0), '0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 32'h0, 0, 1);
            checkOutput("post-rst out_valid", int'(oValid[0]), 0);
        end

        for (int c = 0; c < 3000; c++)
            applyStimulus(($urandom_range(0, 3) != 0), randInst(),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));

        applyStimulus(0, 32'h0, 0, 1);
        applyStimulus(0, 32'h0, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
